// File: rtl/seg_display_scheduler.sv
// seg_display_scheduler
// Shares a two-digit common-cathode seven-segment display between three requesters:
// live note/octave (req[0], level), octave-change event (req[1], pulse) and system
// message event (req[2], pulse). Ownership is arbitrated once per scan frame and the
// owner's pattern is latched at that boundary, so a frame never mixes two sources.
// SEG1/SEG2 are scanned with an all-off blanking slot between digits.
// Optional feature macro: DISP_DP_HOLD_EN (decimal point lit on SEG2 while an event
// hold is running). Default build ties seg_dp low.
module seg_display_scheduler #(
    parameter int unsigned MUX_COUNT_MAX = 250000,
    parameter int unsigned BLANK_CYCLES  = 500,
    parameter int unsigned HOLD_CYCLES   = 50000000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [2:0]  req,
    input  logic [13:0] pat0,
    input  logic [13:0] pat1,
    input  logic [13:0] pat2,
    output logic [2:0]  grant,
    output logic        busy_hold,
    output logic [6:0]  seg,
    output logic        seg_dp,
    output logic [7:0]  digit_selects
);

    // state   | meaning
    // SCAN_D1 | SEG1 selected, driving latch[6:0]
    // BLANK1  | all digits off between SEG1 and SEG2
    // SCAN_D2 | SEG2 selected, driving latch[13:7]
    // BLANK2  | all digits off; leaving it is the frame boundary
    typedef enum logic [1:0] {
        SCAN_D1 = 2'd0,
        BLANK1  = 2'd1,
        SCAN_D2 = 2'd2,
        BLANK2  = 2'd3
    } scan_state_t;

    localparam int unsigned SLOT_MAX = (MUX_COUNT_MAX > BLANK_CYCLES) ? MUX_COUNT_MAX : BLANK_CYCLES;
    localparam int CNT_W  = $clog2(SLOT_MAX + 1);
    localparam int HOLD_W = $clog2(HOLD_CYCLES + 1);

    scan_state_t      state, state_next;
    logic [CNT_W-1:0] cnt, cnt_next;
    logic             slot_last;
    logic             boundary;

    logic [2:1]        pend, pend_next, pend_clr;
    logic [HOLD_W-1:0] hold, hold_next;
    logic [2:0]        cand, grant_next;
    logic              win;
    logic [13:0]       latch, latch_next;
    logic [6:0]        seg_next;
    logic [7:0]        sel_next;

    // Scan state register and slot counter; reset parks the scan at the start of BLANK2.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= BLANK2;
            cnt   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    // Slot sequencing: each slot ends when its counter reaches the slot length minus one.
    always_comb begin
        state_next = state;
        cnt_next   = cnt + 1'b1;
        slot_last  = 1'b0;
        case (state)
            SCAN_D1, SCAN_D2: slot_last = (cnt == CNT_W'(MUX_COUNT_MAX - 1));
            default:          slot_last = (cnt == CNT_W'(BLANK_CYCLES - 1));
        endcase
        if (slot_last) begin
            cnt_next = '0;
            case (state)
                SCAN_D1: state_next = BLANK1;
                BLANK1:  state_next = SCAN_D2;
                SCAN_D2: state_next = BLANK2;
                default: state_next = SCAN_D1;
            endcase
        end
    end

    assign boundary = slot_last && (state == BLANK2);

    // Arbitration, hold countdown, pending capture and frame latch.
    always_comb begin
        cand = 3'b000;
        if (pend[2])      cand = 3'b100;
        else if (pend[1]) cand = 3'b010;
        else if (req[0])  cand = 3'b001;

        // One-hot codes compare in priority order, so >= covers both preemption
        // and a re-triggered current owner.
        win = (cand != 3'b000) && ((hold == '0) || (cand >= grant));

        grant_next = grant;
        pend_clr   = 2'b00;
        hold_next  = (hold != '0) ? hold - 1'b1 : hold;
        if (boundary) begin
            if (win) begin
                grant_next = cand;
                pend_clr   = cand[2:1];
                hold_next  = (cand[2] || cand[1]) ? HOLD_W'(HOLD_CYCLES) : '0;
            end else if (hold == '0) begin
                grant_next = 3'b000;
            end
        end

        // A pulse on the granting edge re-arms its pending bit.
        pend_next = (pend & ~pend_clr) | req[2:1];

        latch_next = latch;
        if (boundary) begin
            case (grant_next)
                3'b100:  latch_next = pat2;
                3'b010:  latch_next = pat1;
                3'b001:  latch_next = pat0;
                default: latch_next = '0;
            endcase
        end
    end

    // Output decode for the state being entered, so the pins change on the entry edge.
    always_comb begin
        seg_next = '0;
        sel_next = '0;
        case (state_next)
            SCAN_D1: begin
                sel_next = 8'h02;
                seg_next = latch_next[6:0];
            end
            SCAN_D2: begin
                sel_next = 8'h04;
                seg_next = latch_next[13:7];
            end
            default: begin
                sel_next = '0;
                seg_next = '0;
            end
        endcase
    end

    // Arbitration state and registered display outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend          <= '0;
            hold          <= '0;
            grant         <= '0;
            latch         <= '0;
            busy_hold     <= 1'b0;
            seg           <= '0;
            digit_selects <= '0;
        end else begin
            pend          <= pend_next;
            hold          <= hold_next;
            grant         <= grant_next;
            latch         <= latch_next;
            busy_hold     <= (hold_next != '0);
            seg           <= seg_next;
            digit_selects <= sel_next;
        end
    end

`ifdef DISP_DP_HOLD_EN
    // Decimal point on SEG2 flags event content while its hold is still running.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) seg_dp <= 1'b0;
        else        seg_dp <= (state_next == SCAN_D2) && (hold_next != '0);
    end
`else
    assign seg_dp = 1'b0;
`endif

endmodule
